// File: rtl/tone_pkg.sv
// tone_pkg -- shared definitions for the tone generator.
//   NOTE_CHZ : note frequencies in centi-Hz, C4 D E F G A B C5
//   tone_state_t : IDLE / RUN / STOP controller states
//   calc_tc  : constant function giving the half-period terminal count
package tone_pkg;

    localparam int TABLE_NOTES = 8;

    localparam int unsigned NOTE_CHZ [TABLE_NOTES] = '{
        26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } tone_state_t;

    // round(clk_hz / (2*f)) - 1 with f given in centi-Hz; 64-bit math so a
    // 100 MHz clock scaled by 100 cannot overflow. Rounds half up.
    function automatic longint unsigned calc_tc(input longint unsigned clk_hz,
                                                input longint unsigned note_chz);
        longint unsigned half_cycles;
        half_cycles = (clk_hz * 64'd100 + note_chz) / (64'd2 * note_chz);
        return half_cycles - 64'd1;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// tone_divider -- half-period counter with square-wave toggle.
//   clk, reset_n : clock, asynchronous active-low reset
//   count_en     : advance the counter this cycle
//   clear        : force counter and tone to zero (idle)
//   tc           : terminal count; half-period is tc+1 cycles
//   terminal     : high in the cycle the counter wraps and the tone toggles
//   tone_out     : square wave output
module tone_divider
    import tone_pkg::*;
#(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             count_en,
    input  logic             clear,
    input  logic [CNT_W-1:0] tc,
    output logic             terminal,
    output logic             tone_out
);

    logic [CNT_W-1:0] count;

    // >= rather than == so a counter that somehow sits above tc still wraps.
    assign terminal = count_en && (count >= tc);

    // Counter and tone flip-flop: wrap to zero and toggle in the same cycle,
    // so tc = 0 produces a toggle on every enabled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            tone_out <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            tone_out <= 1'b0;
        end else if (terminal) begin
            count    <= '0;
            tone_out <= ~tone_out;
        end else if (count_en) begin
            count    <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tone_gen.sv
// tone_gen -- musical square-wave tone generator with glitch-free note changes.
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : level request for a tone
//   note_sel     : note index 0..NUM_NOTES-1 (C4..C5)
//   octave       : upward octave shift (terminal count shifted right)
//   note_valid   : strobe capturing note_sel/octave into a pending slot
//   note_ack     : one-cycle pulse when a pending request takes effect
//   tone_out     : 50% duty square wave
//   active_note  : note currently in use
//   active       : high while in RUN or STOP
module tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int NUM_NOTES = 8,
    parameter int CNT_W     = 18,
    parameter int OCT_W     = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [$clog2(NUM_NOTES)-1:0] note_sel,
    input  logic [OCT_W-1:0]             octave,
    input  logic                         note_valid,
    output logic                         note_ack,
    output logic                         tone_out,
    output logic [$clog2(NUM_NOTES)-1:0] active_note,
    output logic                         active
);

    localparam int SEL_W = $clog2(NUM_NOTES);
    localparam logic [SEL_W:0] NOTE_LIMIT = (SEL_W + 1)'(NUM_NOTES);

    tone_state_t      state;
    logic [OCT_W-1:0] active_oct;
    logic             pend_valid;
    logic [SEL_W-1:0] pend_sel;
    logic [OCT_W-1:0] pend_oct;

    logic             terminal;
    logic             stop_quiet;
    logic             count_en;
    logic             div_clear;
    logic             capture;
    logic             apply;
    logic [CNT_W-1:0] tc_cur;

    // Per-note terminal counts, fixed at elaboration from the clock rate.
    logic [CNT_W-1:0] tc_table [NUM_NOTES];

    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_tc
        localparam int TBL_IDX = (g < TABLE_NOTES) ? g : TABLE_NOTES - 1;
        localparam longint unsigned TC_FULL =
            calc_tc(64'(CLK_HZ), 64'(NOTE_CHZ[TBL_IDX]));
        assign tc_table[g] = CNT_W'(TC_FULL);
    end

    assign tc_cur = tc_table[active_note] >> active_oct;

    // Stopping while the tone is already low: drop straight to idle so no
    // partial high pulse can be started.
    assign stop_quiet = (state == ST_STOP) && !enable && !tone_out;
    assign count_en   = (state == ST_RUN) || ((state == ST_STOP) && !stop_quiet);
    assign div_clear  = (state == ST_IDLE) || stop_quiet;

    // Out-of-range note indices are dropped entirely.
    assign capture = note_valid && ({1'b0, note_sel} < NOTE_LIMIT);

    // Note changes only land on a toggle so no half-period is ever shortened;
    // when idle there is no phase to protect so they land at once.
    assign apply = pend_valid && ((state == ST_IDLE) || terminal);

    tone_divider #(
        .CNT_W (CNT_W)
    ) u_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (count_en),
        .clear    (div_clear),
        .tc       (tc_cur),
        .terminal (terminal),
        .tone_out (tone_out)
    );

    // Run/stop controller. STOP keeps the divider running until the high
    // phase finishes, so the last pulse is always full length; re-enabling
    // in STOP resumes RUN with the counter untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state  <= ST_RUN;
                        active <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (enable) begin
                        state <= ST_RUN;
                    end else if (!tone_out || terminal) begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

    // Pending request slot and active note. The apply takes the older value
    // first; a strobe arriving in the same cycle refills the slot afterwards,
    // and repeated strobes simply overwrite it so only one ack results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            note_ack    <= 1'b0;
            active_note <= '0;
            active_oct  <= '0;
            pend_valid  <= 1'b0;
            pend_sel    <= '0;
            pend_oct    <= '0;
        end else begin
            note_ack <= apply;
            if (apply) begin
                active_note <= pend_sel;
                active_oct  <= pend_oct;
                pend_valid  <= 1'b0;
            end
            if (capture) begin
                pend_sel   <= note_sel;
                pend_oct   <= octave;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen -- directed bench for tone_gen at a 100 kHz clock.
// Half-periods at this rate: A (idx 5) 114, A+1 oct 57, C4 (idx 0) 191,
// C4+1 oct 96.
module tb_tone_gen;

    localparam int CLK_HZ     = 100_000;
    localparam int HP_A       = 114;
    localparam int HP_A_OCT1  = 57;
    localparam int HP_C4      = 191;
    localparam int HP_C4_OCT1 = 96;
    localparam int LIMIT      = 400;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       note_valid;
    logic [2:0] note_sel;
    logic [1:0] octave;
    logic       note_ack;
    logic       tone_out;
    logic [2:0] active_note;
    logic       active;

    int n_checks = 0;
    int n_fail   = 0;
    int cycles;
    int acks;
    int highs;
    int actives;
    logic prev_tone;

    tone_gen #(
        .CLK_HZ    (CLK_HZ),
        .NUM_NOTES (8),
        .CNT_W     (18),
        .OCT_W     (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .note_sel    (note_sel),
        .octave      (octave),
        .note_valid  (note_valid),
        .note_ack    (note_ack),
        .tone_out    (tone_out),
        .active_note (active_note),
        .active      (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic vld,
                                 input logic [2:0] sel, input logic [1:0] oct);
        enable     = en;
        note_valid = vld;
        note_sel   = sel;
        octave     = oct;
    endtask

    task automatic strobe(input logic [2:0] sel, input logic [1:0] oct);
        applyStimulus(enable, 1'b1, sel, oct);
        tick();
        note_valid = 1'b0;
    endtask

    // Ticks until tone_out changes; returns ticks taken and acks seen before
    // the toggling tick.
    task automatic waitToggle(input string tag, output int ncyc, output int nack);
        logic prev;
        bit   done;
        prev = tone_out;
        ncyc = 0;
        nack = 0;
        done = 0;
        while (!done && ncyc < LIMIT) begin
            tick();
            ncyc++;
            if (tone_out != prev) done = 1;
            else if (note_ack) nack++;
        end
        if (!done) checkOutput({tag, " timeout"}, 0, 1);
    endtask

    task automatic watchCycles(input int n, output int nhigh, output int nack, output int nact);
        nhigh = 0;
        nack  = 0;
        nact  = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tone_out) nhigh++;
            if (note_ack) nack++;
            if (active)   nact++;
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0);
        reset_n = 1'b0;
        #2;
        checkOutput("reset tone", tone_out, 0);
        checkOutput("reset active", active, 0);
        checkOutput("reset ack", note_ack, 0);
        checkOutput("reset note", active_note, 0);
        #20;
        reset_n = 1'b1;
        tick();

        // Disabled: stays silent.
        watchCycles(30, highs, acks, actives);
        checkOutput("idle highs", highs, 0);
        checkOutput("idle active", actives, 0);

        // Note A captured in idle, applied next cycle, then tone starts.
        strobe(3'd5, 2'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 2'd0);
        tick();
        checkOutput("idle apply ack", note_ack, 1);
        checkOutput("idle apply note", active_note, 5);
        checkOutput("run active", active, 1);
        checkOutput("run start tone", tone_out, 0);
        waitToggle("A first", cycles, acks);
        checkOutput("A first half", cycles, HP_A);
        checkOutput("A single ack", acks, 0);
        waitToggle("A second", cycles, acks);
        checkOutput("A second half", cycles, HP_A);

        // Switch to C4 mid-phase: ack only at the next toggle.
        repeat (20) tick();
        strobe(3'd0, 2'd0);
        waitToggle("to C4", cycles, acks);
        checkOutput("to C4 remaining", cycles, HP_A - 21);
        checkOutput("to C4 early ack", acks, 0);
        checkOutput("to C4 ack", note_ack, 1);
        checkOutput("to C4 note", active_note, 0);
        waitToggle("C4 half1", cycles, acks);
        checkOutput("C4 half1", cycles, HP_C4);
        checkOutput("C4 half1 acks", acks, 0);
        waitToggle("C4 half2", cycles, acks);
        checkOutput("C4 half2", cycles, HP_C4);

        // Back to A, then two strobes in one phase: last one (oct 1) wins.
        strobe(3'd5, 2'd0);
        waitToggle("to A", cycles, acks);
        checkOutput("to A remaining", cycles, HP_C4 - 1);
        checkOutput("to A ack", note_ack, 1);
        checkOutput("to A note", active_note, 5);
        waitToggle("A half", cycles, acks);
        checkOutput("A half", cycles, HP_A);
        repeat (5) tick();
        strobe(3'd0, 2'd0);
        repeat (5) tick();
        strobe(3'd5, 2'd1);
        waitToggle("to A oct1", cycles, acks);
        checkOutput("to A oct1 remaining", cycles, HP_A - 12);
        checkOutput("to A oct1 early ack", acks, 0);
        checkOutput("to A oct1 ack", note_ack, 1);
        checkOutput("to A oct1 note", active_note, 5);
        waitToggle("A oct1 half1", cycles, acks);
        checkOutput("A oct1 half1", cycles, HP_A_OCT1);
        checkOutput("A oct1 extra ack", acks, 0);
        waitToggle("A oct1 half2", cycles, acks);
        checkOutput("A oct1 half2", cycles, HP_A_OCT1);

        // Strobe landing on the apply cycle: older value applied, newer held.
        prev_tone = tone_out;
        strobe(3'd0, 2'd1);
        repeat (55) tick();
        applyStimulus(1'b1, 1'b1, 3'd5, 2'd0);
        tick();
        note_valid = 1'b0;
        checkOutput("overlap toggle", tone_out, int'(!prev_tone));
        checkOutput("overlap ack", note_ack, 1);
        checkOutput("overlap older note", active_note, 0);
        waitToggle("held apply", cycles, acks);
        checkOutput("C4 oct1 half", cycles, HP_C4_OCT1);
        checkOutput("held early ack", acks, 0);
        checkOutput("held ack", note_ack, 1);
        checkOutput("held note", active_note, 5);
        waitToggle("A after held", cycles, acks);
        checkOutput("A after held", cycles, HP_A);

        // Disable 10 cycles into a high phase: high phase runs to full length.
        if (tone_out == 1'b0) waitToggle("find high", cycles, acks);
        repeat (10) tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0);
        waitToggle("stop", cycles, acks);
        checkOutput("stop high remainder", cycles, HP_A - 10);
        checkOutput("stop tone", tone_out, 0);
        checkOutput("stop active", active, 0);
        watchCycles(20, highs, acks, actives);
        checkOutput("stopped highs", highs, 0);
        checkOutput("stopped active", actives, 0);

        // Reset mid-high-phase with a request pending.
        applyStimulus(1'b1, 1'b0, 3'd0, 2'd0);
        tick();
        checkOutput("restart active", active, 1);
        waitToggle("restart", cycles, acks);
        checkOutput("restart half", cycles, HP_A);
        checkOutput("restart tone high", tone_out, 1);
        repeat (5) tick();
        strobe(3'd0, 2'd0);
        repeat (3) tick();
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset tone", tone_out, 0);
        checkOutput("async reset active", active, 0);
        checkOutput("async reset note", active_note, 0);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        watchCycles(30, highs, acks, actives);
        checkOutput("post reset acks", acks, 0);
        checkOutput("post reset highs", highs, 0);
        applyStimulus(1'b1, 1'b0, 3'd0, 2'd0);
        tick();
        checkOutput("post reset active", active, 1);
        waitToggle("post reset", cycles, acks);
        checkOutput("post reset half", cycles, HP_C4);
        checkOutput("post reset stale ack", acks + int'(note_ack), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
